// File: rtl/vga_sync.sv
// VGA timing generator: divides clk down to a pixel tick and produces the
// horizontal/vertical counters, registered active-low syncs and frame marker.
module vga_sync #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned HD       = 640,
    parameter int unsigned HF       = 16,
    parameter int unsigned HR       = 96,
    parameter int unsigned HB       = 48,
    parameter int unsigned VD       = 480,
    parameter int unsigned VF       = 10,
    parameter int unsigned VR       = 2,
    parameter int unsigned VB       = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_tick
);

    localparam int unsigned CW = 10;
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    localparam logic [CW-1:0] H_LAST       = CW'(HD + HF + HR + HB - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(VD + VF + VR + VB - 1);
    localparam logic [CW-1:0] H_VISIBLE    = CW'(HD);
    localparam logic [CW-1:0] V_VISIBLE    = CW'(VD);
    localparam logic [CW-1:0] H_SYNC_FIRST = CW'(HD + HF);
    localparam logic [CW-1:0] H_SYNC_LAST  = CW'(HD + HF + HR - 1);
    localparam logic [CW-1:0] V_SYNC_FIRST = CW'(VD + VF);
    localparam logic [CW-1:0] V_SYNC_LAST  = CW'(VD + VF + VR - 1);

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_next;
    logic [CW-1:0] h_q;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_q;
    logic [CW-1:0] v_next;
    logic          h_at_end;
    logic          v_at_end;
    logic          hsync_next;
    logic          vsync_next;

    // Pixel tick divider; >= also recovers any out-of-range value.
    always_comb begin
        tick_next = tick_q + TW'(1);
        if (tick_q >= TICK_LAST) begin
            tick_next = '0;
        end
    end

    assign p_tick   = (tick_q == TICK_LAST);
    assign h_at_end = (h_q >= H_LAST);
    assign v_at_end = (v_q >= V_LAST);

    // Counters move only on a pixel tick; line end carries into the line count.
    always_comb begin
        h_next = h_q;
        v_next = v_q;
        if (p_tick) begin
            if (h_at_end) begin
                h_next = '0;
                if (v_at_end) begin
                    v_next = '0;
                end else begin
                    v_next = v_q + CW'(1);
                end
            end else begin
                h_next = h_q + CW'(1);
            end
        end
    end

    // Syncs are decoded from the next counts so they switch with the counters.
    always_comb begin
        hsync_next = 1'b1;
        vsync_next = 1'b1;
        if ((h_next >= H_SYNC_FIRST) && (h_next <= H_SYNC_LAST)) begin
            hsync_next = 1'b0;
        end
        if ((v_next >= V_SYNC_FIRST) && (v_next <= V_SYNC_LAST)) begin
            vsync_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            h_q    <= '0;
            v_q    <= '0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
        end else begin
            tick_q <= tick_next;
            h_q    <= h_next;
            v_q    <= v_next;
            hsync  <= hsync_next;
            vsync  <= vsync_next;
        end
    end

    assign pixel_x    = h_q;
    assign pixel_y    = v_q;
    assign video_on   = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
    assign frame_tick = p_tick && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench for vga_sync: one default-timing instance and one shrunken
// instance (16x12 pixels, 2 clks/pixel) so whole frames fit in a short run.
module tb_vga_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a;
    logic       hsync_a, vsync_a, video_on_a, p_tick_a, frame_tick_a;
    logic [9:0] pixel_x_a, pixel_y_a;
    logic       rst_b;
    logic       hsync_b, vsync_b, video_on_b, p_tick_b, frame_tick_b;
    logic [9:0] pixel_x_b, pixel_y_b;

    vga_sync u_a (
        .clk        (clk),
        .reset      (rst_a),
        .hsync      (hsync_a),
        .vsync      (vsync_a),
        .video_on   (video_on_a),
        .p_tick     (p_tick_a),
        .pixel_x    (pixel_x_a),
        .pixel_y    (pixel_y_a),
        .frame_tick (frame_tick_a)
    );

    // Small geometry: hsync low x=10..12, vsync low y=8..9, visible 8x6.
    vga_sync #(
        .TICK_DIV (2),
        .HD (8), .HF (2), .HR (3), .HB (3),
        .VD (6), .VF (2), .VR (2), .VB (2)
    ) u_b (
        .clk        (clk),
        .reset      (rst_b),
        .hsync      (hsync_b),
        .vsync      (vsync_b),
        .video_on   (video_on_b),
        .p_tick     (p_tick_b),
        .pixel_x    (pixel_x_b),
        .pixel_y    (pixel_y_b),
        .frame_tick (frame_tick_b)
    );

    localparam int KIND_OBS_A = 0;
    localparam int KIND_OBS_B = 1;
    localparam int KIND_HSLO_A = 2;
    localparam int KIND_VSLO_B = 3;
    localparam int KIND_FTCNT_B = 4;
    localparam int KIND_FTPER_B = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        int          base;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    int cyc = 0;
    int cnt_hslo_a = 0;
    int cnt_vslo_b = 0;
    int cnt_ft_b = 0;
    int last_ft_b = -1;
    int ft_period_b = 0;

    int ka = 0;
    int kb = 0;

    function automatic logic [31:0] pack(input logic hs, input logic vs, input logic vo,
                                         input logic pt, input logic ft,
                                         input int x, input int y);
        return {7'd0, hs, vs, vo, pt, ft, 10'(x), 10'(y)};
    endfunction

    task automatic push(input string n, input int kind, input logic [31:0] e, input int base);
        exp_t t;
        t.name = n;
        t.kind = kind;
        t.exp  = e;
        t.base = base;
        sbq.push_back(t);
    endtask

    task automatic obs_a(input string n, input logic hs, input logic vs, input logic vo,
                         input logic pt, input logic ft, input int x, input int y);
        push(n, KIND_OBS_A, pack(hs, vs, vo, pt, ft, x, y), 0);
    endtask

    task automatic obs_b(input string n, input logic hs, input logic vs, input logic vo,
                         input logic pt, input logic ft, input int x, input int y);
        push(n, KIND_OBS_B, pack(hs, vs, vo, pt, ft, x, y), 0);
    endtask

    // Advance to just after the target edge counted from the last reset release.
    task automatic to_a(input int target);
        while (ka < target) begin
            @(posedge clk);
            #1;
            ka++;
        end
    endtask

    task automatic to_b(input int target);
        while (kb < target) begin
            @(posedge clk);
            #1;
            kb++;
        end
    endtask

    // Monitor: compare every queued expectation against what the DUT shows now.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                case (e.kind)
                    KIND_OBS_A: act = pack(hsync_a, vsync_a, video_on_a, p_tick_a, frame_tick_a,
                                           int'(pixel_x_a), int'(pixel_y_a));
                    KIND_OBS_B: act = pack(hsync_b, vsync_b, video_on_b, p_tick_b, frame_tick_b,
                                           int'(pixel_x_b), int'(pixel_y_b));
                    KIND_HSLO_A:  act = 32'(cnt_hslo_a - e.base);
                    KIND_VSLO_B:  act = 32'(cnt_vslo_b - e.base);
                    KIND_FTCNT_B: act = 32'(cnt_ft_b - e.base);
                    default:      act = 32'(ft_period_b);
                endcase
                n_chk++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h (obs = hs,vs,vo,pt,ft,x[10],y[10])",
                             e.name, act, e.exp);
                end
            end
            if (!hsync_a) cnt_hslo_a++;
            if (!vsync_b) cnt_vslo_b++;
            if (frame_tick_b) begin
                cnt_ft_b++;
                if (last_ft_b >= 0) ft_period_b = cyc - last_ft_b;
                last_ft_b = cyc;
            end
            cyc++;
        end
    end

    initial begin
        int base;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        obs_a("a_reset", 1, 1, 1, 0, 0, 0, 0);
        obs_b("b_reset", 1, 1, 1, 0, 0, 0, 0);

        // Default instance: tick cadence, line timing, line wrap.
        rst_a = 1'b0;
        ka = 0;
        for (int k = 1; k <= 12; k++) begin
            to_a(k);
            obs_a($sformatf("a_start_k%0d", k), 1, 1, 1, (k % 4) == 3, 0, k / 4, 0);
        end
        to_a(2559); obs_a("a_x639",  1, 1, 1, 1, 0, 639, 0);
        to_a(2560); obs_a("a_x640",  1, 1, 0, 0, 0, 640, 0);
        to_a(2623); obs_a("a_x655",  1, 1, 0, 1, 0, 655, 0);
        to_a(2624); obs_a("a_x656",  0, 1, 0, 0, 0, 656, 0);
        to_a(3007); obs_a("a_x751",  0, 1, 0, 1, 0, 751, 0);
        to_a(3008); obs_a("a_x752",  1, 1, 0, 0, 0, 752, 0);
        base = cnt_hslo_a;
        to_a(6208); push("a_hsync_low_clks_per_line", KIND_HSLO_A, 32'd384, base);
        to_a(35195); obs_a("a_x798_y10", 1, 1, 0, 1, 0, 798, 10);
        to_a(35196); obs_a("a_x799_y10", 1, 1, 0, 0, 0, 799, 10);
        to_a(35199); obs_a("a_x799_tick", 1, 1, 0, 1, 0, 799, 10);
        to_a(35200); obs_a("a_wrap_y11", 1, 1, 1, 0, 0, 0, 11);
        to_a(35203); obs_a("a_tick_pre_rst", 1, 1, 1, 1, 0, 0, 11);

        // Reset lands on an edge where p_tick is high and is then held.
        rst_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            obs_a($sformatf("a_rst_hold%0d", i), 1, 1, 1, 0, 0, 0, 0);
        end
        rst_a = 1'b0;
        ka = 0;
        to_a(3); obs_a("a_rel_k3", 1, 1, 1, 1, 0, 0, 0);
        to_a(4); obs_a("a_rel_k4", 1, 1, 1, 0, 0, 1, 0);

        // Small instance: vertical sync, frame wrap, frame period, mid-frame reset.
        rst_b = 1'b0;
        kb = 0;
        to_b(255); obs_b("b_y7_end",    1, 1, 0, 1, 0, 15, 7);
        to_b(256); obs_b("b_y8_vs",     1, 0, 0, 0, 0, 0, 8);
        to_b(319); obs_b("b_y9_end",    1, 0, 0, 1, 0, 15, 9);
        to_b(320); obs_b("b_y10",       1, 1, 0, 0, 0, 0, 10);
        to_b(382); obs_b("b_last_notick", 1, 1, 0, 0, 0, 15, 11);
        to_b(383); obs_b("b_frame_tick",  1, 1, 0, 1, 1, 15, 11);
        to_b(384); obs_b("b_frame_wrap",  1, 1, 1, 0, 0, 0, 0);
        to_b(400);
        base = cnt_vslo_b;
        push("b_vsync_low_clks", KIND_VSLO_B, 32'd64, base);
        sbq.delete(sbq.size() - 1);
        begin
            int base_ft;
            base_ft = cnt_ft_b;
            to_b(784);
            push("b_vsync_low_clks_per_frame", KIND_VSLO_B, 32'd64, base);
            push("b_frame_ticks_per_frame", KIND_FTCNT_B, 32'd1, base_ft);
        end
        to_b(790); push("b_frame_period", KIND_FTPER_B, 32'd384, 0);
        to_b(1078); obs_b("b_x11_y9", 0, 0, 0, 0, 0, 11, 9);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        obs_b("b_mid_rst", 1, 1, 1, 0, 0, 0, 0);
        rst_b = 1'b0;
        kb = 0;
        to_b(1); obs_b("b_rel_k1", 1, 1, 1, 1, 0, 0, 0);
        to_b(2); obs_b("b_rel_k2", 1, 1, 1, 0, 0, 1, 0);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        @(posedge clk);
        if (sbq.size() > 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter TICK_DIV, default 4: system clocks per pixel (100 MHz clk gives a 25 MHz pixel rate).
REQ-002 Parameters HD/HF/HR/HB, defaults 640/16/96/48: horizontal visible, front porch, retrace and back porch widths, in pixels.
REQ-003 Parameters VD/VF/VR/VB, defaults 480/10/2/33: vertical visible, front porch, retrace and back porch widths, in lines.
REQ-004 clk  input  1  system clock; all state is updated on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 hsync  output  1  horizontal sync, active low, registered.
REQ-007 vsync  output  1  vertical sync, active low, registered.
REQ-008 video_on  output  1  high while the current pixel is in the visible area.
REQ-009 p_tick  output  1  one-clk pulse marking each pixel-clock advance.
REQ-010 pixel_x  output  10  current horizontal count, 0..HD+HF+HR+HB-1.
REQ-011 pixel_y  output  10  current vertical count, 0..VD+VF+VR+VB-1.
REQ-012 frame_tick  output  1  one-clk pulse on the last pixel of a frame.

Function
REQ-013 Tick divider: a mod-TICK_DIV counter increments every clk, wraps TICK_DIV-1 -> 0, and drives p_tick=1 only while it equals TICK_DIV-1.
REQ-014 H_TOTAL=HD+HF+HR+HB (800) and V_TOTAL=VD+VF+VR+VB (525) are used; counters are 10-bit and unsigned.
REQ-015 h_count advances only in a clk where p_tick=1: it increments, and wraps H_TOTAL-1 -> 0.
REQ-016 v_count advances only in a clk where p_tick=1 and h_count=H_TOTAL-1: it increments, and wraps V_TOTAL-1 -> 0.
REQ-017 In all other cycles both counters hold.
REQ-018 hsync is registered from the next-state h_count: 0 when next h_count is in [HD+HF, HD+HF+HR-1] (656..751), else 1; it changes in the same edge as pixel_x.
REQ-019 vsync is registered from the next-state v_count: 0 when next v_count is in [VD+VF, VD+VF+VR-1] (490..491), else 1; it changes in the same edge as pixel_y.
REQ-020 pixel_x=h_count and pixel_y=v_count, directly from registers.
REQ-021 video_on=(h_count<HD)&&(v_count<VD), combinational from the registered counts.
REQ-022 frame_tick=p_tick && h_count=H_TOTAL-1 && v_count=V_TOTAL-1.
REQ-023 At the frame boundary, a line wrap and a frame wrap fall on the same p_tick; both counters reach 0 on that edge.
REQ-024 Counts outside the legal range are never produced; if reached, the next p_tick forces the counter to 0.
REQ-025 Each frame is exactly H_TOTAL*V_TOTAL*TICK_DIV clks (1,680,000 at defaults).

Reset
REQ-026 While reset=1 at a clk edge, the tick counter, h_count and v_count go to 0, and hsync=1, vsync=1.
REQ-027 During and right after reset, p_tick=0, frame_tick=0, video_on=1, pixel_x=0 and pixel_y=0.
REQ-028 Reset takes priority over a simultaneous p_tick.
REQ-029 Reset asserted mid-frame aborts the frame.
REQ-030 The first p_tick after reset is released occurs TICK_DIV clks after the release edge (clk 4 at default).

Verification
REQ-031 Reset, then release, then run 12 clks -> p_tick high on clks 4, 8 and 12 only, and pixel_x steps 0->1->2->3.
REQ-032 Run one full line -> hsync=0 exactly for pixel_x 656..751 (96 pixels, 384 clks), and video_on falls when pixel_x goes 639->640.
REQ-033 At pixel_x=799, pixel_y=10, on p_tick -> pixel_x=0 and pixel_y=11; a p_tick at pixel_x=798 leaves pixel_y unchanged.
REQ-034 Run a full frame -> vsync=0 for pixel_y 490..491 (1600 pixels), frame_tick pulses once at (799,524), next state (0,0), and the period is 1,680,000 clks.
REQ-035 Assert reset for 1 clk at pixel (700,491) -> next cycle hsync=1, vsync=1, pixel_x=0, pixel_y=0, video_on=1, and no frame_tick.
REQ-036 Hold reset coincident with p_tick -> counters stay 0 and no increment occurs.
